// File: rtl/pwm_multichannel_pkg.sv
// Shared types and default sizing for the multichannel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_e;

    localparam int DEF_NUM_CH  = 16;
    localparam int DEF_DUTY_W  = 8;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Register-bank side controls and pin-side outputs of the PWM block.
// PWM_INVERT_EN adds the per-channel polarity vector pol.
interface pwm_multichannel_if #(
    parameter int NUM_CH  = pwm_pkg::DEF_NUM_CH,
    parameter int DUTY_W  = pwm_pkg::DEF_DUTY_W,
    parameter int PRESC_W = pwm_pkg::DEF_PRESC_W
);
    logic [NUM_CH-1:0]        en_out;
    logic [NUM_CH-1:0]        en_pwm;
    logic [NUM_CH*DUTY_W-1:0] duty;
    logic                     center_mode;
    logic [PRESC_W-1:0]       prescale;
`ifdef PWM_INVERT_EN
    logic [NUM_CH-1:0]        pol;
`endif
    logic [NUM_CH-1:0]        out;
    logic                     period_start;

    modport master (
        output en_out,
        output en_pwm,
        output duty,
        output center_mode,
        output prescale,
`ifdef PWM_INVERT_EN
        output pol,
`endif
        input  out,
        input  period_start
    );

    modport slave (
        input  en_out,
        input  en_pwm,
        input  duty,
        input  center_mode,
        input  prescale,
`ifdef PWM_INVERT_EN
        input  pol,
`endif
        output out,
        output period_start
    );

endinterface

// File: rtl/pwm_multichannel_channel.sv
// One PWM channel: duty shadow loaded at the period boundary, compare, registered pin.
// PWM_INVERT_EN adds i_pol, which inverts the PWM level of enabled PWM channels.
module pwm_channel #(
    parameter int DUTY_W = pwm_pkg::DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic [DUTY_W-1:0] i_cnt,
    input  logic              i_en_out,
    input  logic              i_en_pwm,
`ifdef PWM_INVERT_EN
    input  logic              i_pol,
`endif
    output logic              o_out
);
    logic [DUTY_W-1:0] r_duty;
    logic              w_level;
    logic              w_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty <= '0;
        end else if (i_load) begin
            r_duty <= i_duty;
        end
    end

    // Full-scale duty must stay high even at cnt == MAX.
    assign w_level = (r_duty == '1) || (i_cnt < r_duty);

`ifdef PWM_INVERT_EN
    assign w_pwm = w_level ^ i_pol;
`else
    assign w_pwm = w_level;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_out <= 1'b0;
        end else begin
            o_out <= i_en_out & (i_en_pwm ? w_pwm : 1'b1);
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH-channel PWM: prescaler, shared edge/center counter, boundary-shadowed duty and mode.
// Optional PWM_INVERT_EN adds per-channel output polarity (pol).
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DUTY_W  = DEF_DUTY_W,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic clk,
    input  logic rst,
    pwm_multichannel_if.slave bus
);
    localparam logic [DUTY_W-1:0] MAX = '1;

    logic [PRESC_W-1:0] r_psc;
    logic               w_tick;
    logic [DUTY_W-1:0]  r_cnt;
    logic [DUTY_W-1:0]  w_cnt_nxt;
    pwm_dir_e           r_dir;
    pwm_dir_e           w_dir_nxt;
    pwm_mode_e          r_mode;
    logic               w_bnd;
    logic               r_bnd;
    logic               r_period_start;
    logic [NUM_CH-1:0]  w_out;

    // A shrinking prescale lets the count run past it to all-ones and wrap naturally.
    assign w_tick = (r_psc == bus.prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc <= '0;
        end else if (w_tick) begin
            r_psc <= '0;
        end else begin
            r_psc <= r_psc + PRESC_W'(1);
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (r_mode == PWM_EDGE) begin
            w_cnt_nxt = r_cnt + DUTY_W'(1);
            w_dir_nxt = UP;
        end else if (r_dir == UP) begin
            w_cnt_nxt = r_cnt + DUTY_W'(1);
            if (w_cnt_nxt == MAX) begin
                w_dir_nxt = DOWN;
            end
        end else begin
            w_cnt_nxt = r_cnt - DUTY_W'(1);
            if (w_cnt_nxt == '0) begin
                w_dir_nxt = UP;
            end
        end
    end

    assign w_bnd = w_tick && (w_cnt_nxt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dir  <= UP;
            r_mode <= PWM_EDGE;
        end else if (w_tick) begin
            r_cnt <= w_cnt_nxt;
            // A mode change at the boundary always restarts counting upward from 0.
            r_dir <= w_bnd ? UP : w_dir_nxt;
            if (w_bnd) begin
                r_mode <= bus.center_mode ? PWM_CENTER : PWM_EDGE;
            end
        end
    end

    // Two stages so the pulse lines up with the first output of the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bnd          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_bnd          <= w_bnd;
            r_period_start <= r_bnd;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_bnd),
            .i_duty   (bus.duty[c*DUTY_W +: DUTY_W]),
            .i_cnt    (r_cnt),
            .i_en_out (bus.en_out[c]),
            .i_en_pwm (bus.en_pwm[c]),
`ifdef PWM_INVERT_EN
            .i_pol    (bus.pol[c]),
`endif
            .o_out    (w_out[c])
        );
    end

    assign bus.out          = w_out;
    assign bus.period_start = r_period_start;

endmodule
